// File: rtl/bm_rng_pkg.sv
// Shared types for the Box-Muller generator and its downstream sample serializer.
package bm_rng_pkg;

  localparam int SAMPLE_W = 16;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] x1;
    logic signed [SAMPLE_W-1:0] x0;
  } bm_pair_t;

  typedef enum logic [1:0] {EMPTY, X0, X1} bm_ser_state_e;

endpackage

// File: rtl/bm_pair_fifo.sv
// Synchronous FIFO of Gaussian pairs; full/empty are judged by the caller from level.
module bm_pair_fifo
  import bm_rng_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  bm_pair_t                 wdata,
  output bm_pair_t                 rdata,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  bm_pair_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LVL_W'(push) - LVL_W'(pop);
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/bm_sample_serializer.sv
// Buffers Gaussian pairs and serializes them into one ready/valid sample stream.
// Define BM_SER_DROP_CNT_EN to build the saturating drop counter; otherwise drop_cnt is 0.
module bm_sample_serializer
  import bm_rng_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic signed [SAMPLE_W-1:0]  x0_in,
  input  logic signed [SAMPLE_W-1:0]  x1_in,
  input  logic                        enable,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic signed [SAMPLE_W-1:0]  out_data,
  output logic                        out_sel,
  output logic [$clog2(DEPTH):0]      fifo_level,
  output logic [CNT_W-1:0]            drop_cnt,
  input  logic                        clr_drop
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  bm_ser_state_e state;
  bm_pair_t      hold;
  bm_pair_t      in_pair;
  bm_pair_t      fifo_rdata;
  logic          fifo_nempty;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          drop;

  assign in_pair     = '{x1: x1_in, x0: x0_in};
  assign fifo_nempty = (fifo_level != '0);
  assign push_req    = in_valid & enable;
  assign pop         = fifo_nempty & ((state == EMPTY) | ((state == X1) & out_ready));
  // A full FIFO still accepts when the same edge frees a slot.
  assign push        = push_req & ((fifo_level != FULL_LVL) | pop);
  assign drop        = push_req & ~push;

  bm_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (in_pair),
    .rdata (fifo_rdata),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      hold      <= '0;
      out_valid <= 1'b0;
      out_sel   <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (pop) begin
            hold      <= fifo_rdata;
            state     <= X0;
            out_valid <= 1'b1;
            out_sel   <= 1'b0;
          end
        end
        X0: begin
          if (out_ready) begin
            state   <= X1;
            out_sel <= 1'b1;
          end
        end
        X1: begin
          if (out_ready) begin
            out_sel <= 1'b0;
            if (pop) begin
              hold  <= fifo_rdata;
              state <= X0;
            end else begin
              state     <= EMPTY;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          out_sel   <= 1'b0;
        end
      endcase
    end
  end

  // Output mux sits on registers only, so no input reaches out_data combinationally.
  assign out_data = out_sel ? hold.x1 : hold.x0;

`ifdef BM_SER_DROP_CNT_EN
  logic [CNT_W-1:0] drop_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_q <= '0;
    end else if (clr_drop) begin
      drop_q <= CNT_W'(drop);
    end else if (drop && (drop_q != '1)) begin
      drop_q <= drop_q + 1'b1;
    end
  end

  assign drop_cnt = drop_q;
`else
  logic unused_drop;
  assign unused_drop = &{1'b0, clr_drop, drop};
  assign drop_cnt    = '0;
`endif

endmodule

// File: tb/tb_bm_sample_serializer.sv
// Directed bench for bm_sample_serializer with a queue-based reference model.
module tb_bm_sample_serializer;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] x0_in = '0;
  logic [15:0] x1_in = '0;
  logic        enable = 1'b1;
  logic        out_ready = 1'b0;
  logic        clr_drop = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_sel;
  logic [4:0]  fifo_level;
  logic [CNT_W-1:0] drop_cnt;

  bm_sample_serializer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .x0_in      (x0_in),
    .x1_in      (x1_in),
    .enable     (enable),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sel    (out_sel),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt),
    .clr_drop   (clr_drop)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of buffered pairs plus the pair currently on offer.
  logic [31:0] mq[$];
  logic [31:0] m_cur = '0;
  bit          m_have = 0;
  bit          m_half = 0;
  bit          m_stall = 0;
  int          m_drops = 0;
  logic [15:0] got[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_have  = 0;
      m_half  = 0;
      m_stall = 0;
      m_drops = 0;
    end else begin
      int sz;
      bit take, req, acc, drop;
      sz      = mq.size();
      m_stall = m_have && !out_ready;
      take    = (sz > 0) && (!m_have || (m_half && out_ready));
      req     = in_valid && enable;
      acc     = req && ((sz < DEPTH) || take);
      drop    = req && !acc;
      if (m_have && out_ready) begin
        got.push_back(m_half ? m_cur[31:16] : m_cur[15:0]);
        if (!m_half) m_half = 1;
        else m_have = 0;
      end
      if (take) begin
        m_cur  = mq.pop_front();
        m_have = 1;
        m_half = 0;
      end
      if (acc) mq.push_back({x1_in, x0_in});
      if (clr_drop) m_drops = drop ? 1 : 0;
      else if (drop && (m_drops < (2 ** CNT_W) - 1)) m_drops++;
    end
  end

  function automatic int exp_drop(int n);
`ifdef BM_SER_DROP_CNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  bit          chk_en = 0;
  bit          have_pd = 0;
  logic [15:0] pd;
  logic        ps;
  int          dut_peak = 0;

  always @(posedge clk) begin
    #1;
    if (reset && chk_en) begin
      chk("out_valid", out_valid, m_have);
      if (m_have) begin
        chk("out_data", out_data, m_half ? m_cur[31:16] : m_cur[15:0]);
        chk("out_sel", out_sel, m_half);
      end
      if (m_stall && have_pd) begin
        chk("stall_data", out_data, pd);
        chk("stall_sel", out_sel, ps);
      end
      chk("fifo_level", fifo_level, mq.size());
      chk("drop_cnt", drop_cnt, exp_drop(m_drops));
      if (int'(fifo_level) > dut_peak) dut_peak = int'(fifo_level);
      pd = out_data;
      ps = out_sel;
      have_pd = 1;
    end else begin
      have_pd = 0;
    end
  end

  task automatic drive(bit v, logic [15:0] a, logic [15:0] b, bit rdy);
    @(negedge clk);
    in_valid  = v;
    x0_in     = a;
    x1_in     = b;
    out_ready = rdy;
  endtask

  task automatic wait_drain(string name);
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!out_valid && fifo_level == '0) done = 1;
    end
    chk(name, done, 1);
  endtask

  initial begin
    int g0;
    // Reset values while held
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    reset  = 1'b1;
    chk_en = 1;
    repeat (10) @(negedge clk);
    chk("idle_out_valid", out_valid, 0);

    // Single pair, first-sample latency
    drive(1, 16'h1234, 16'hFEDC, 1);
    @(negedge clk); in_valid = 0;
    chk("single_lvl_after_push", fifo_level, 1);
    chk("single_valid_after_push", out_valid, 0);
    @(negedge clk);
    chk("single_x0_valid", out_valid, 1);
    chk("single_x0_data", out_data, 16'h1234);
    chk("single_x0_sel", out_sel, 0);
    @(negedge clk);
    chk("single_x1_data", out_data, 16'hFEDC);
    chk("single_x1_sel", out_sel, 1);
    @(negedge clk);
    chk("single_done_valid", out_valid, 0);

    // Sustained pushes every cycle overflow the buffer
    g0 = got.size();
    for (int i = 0; i < 40; i++) drive(1, 16'h1000 + 16'(i), 16'h2000 + 16'(i), 1);
    @(negedge clk); in_valid = 0;
    chk("tp_model_drops", m_drops, 4);
    chk("tp_drop_cnt", drop_cnt, exp_drop(4));
    wait_drain("tp_drain");
    chk("tp_samples", got.size() - g0, 72);
    chk("tp_first_x0", got[g0], 16'h1000);
    chk("tp_first_x1", got[g0+1], 16'h2000);
    chk("tp_peak", dut_peak, 16);

    // Pseudo-random backpressure
    g0 = got.size();
    for (int i = 0; i < 8; i++)
      drive(1, 16'h3000 + 16'(i), 16'h8000 + 16'(i), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 60; i++) drive(0, 16'h0, 16'h0, 1'($urandom_range(0, 1)));
    out_ready = 1;
    wait_drain("bp_drain");
    chk("bp_samples", got.size() - g0, 16);
    for (int k = 0; k < 8; k++) begin
      chk("bp_order_x0", got[g0+2*k], 16'h3000 + 16'(k));
      chk("bp_order_x1", got[g0+2*k+1], 16'h8000 + 16'(k));
    end

    // Full buffer, drops, enable gating, clear
    @(negedge clk); clr_drop = 1; in_valid = 0; out_ready = 0;
    @(negedge clk); clr_drop = 0;
    chk("clr_no_drop", drop_cnt, 0);
    for (int i = 0; i < 20; i++) drive(1, 16'h4000 + 16'(i), 16'h4800 + 16'(i), 0);
    @(negedge clk); in_valid = 0;
    chk("full_level", fifo_level, 16);
    chk("full_model_drops", m_drops, 3);
    chk("full_drop_cnt", drop_cnt, exp_drop(3));
    @(negedge clk); enable = 0; in_valid = 1;
    @(negedge clk);
    @(negedge clk);
    chk("en_off_drop_cnt", drop_cnt, exp_drop(3));
    enable = 1; in_valid = 1; clr_drop = 1;
    @(negedge clk); clr_drop = 0; in_valid = 0;
    chk("clr_with_drop", drop_cnt, exp_drop(1));
    out_ready = 1;
    wait_drain("full_drain");

    // Reset asserted mid-pair while in the x1 half
    for (int i = 0; i < 6; i++) drive(1, 16'h5000 + 16'(i), 16'h5800 + 16'(i), 0);
    @(negedge clk); in_valid = 0; out_ready = 1;
    @(negedge clk); out_ready = 0;
    chk("mid_level", fifo_level, 5);
    chk("mid_sel", out_sel, 1);
    chk("mid_valid", out_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_level", fifo_level, 0);
    chk("async_rst_data", out_data, 0);
    @(negedge clk); reset = 1'b1;
    g0 = got.size();
    drive(1, 16'h5555, 16'h6666, 1);
    @(negedge clk); in_valid = 0;
    wait_drain("post_rst_drain");
    chk("post_rst_samples", got.size() - g0, 2);
    chk("post_rst_x0", got[g0], 16'h5555);
    chk("post_rst_x1", got[g0+1], 16'h6666);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
